hilo_mult_sequencer: RTL and testbench

Iterative multiply/accumulate sequencer owning the Hi/Lo register pair. It sits in the EX stage beside the ALU. It executes mult, multu, madd and msub as fixed-latency shift-add sequences and services mthi/mtlo writes. While a sequence is in flight, it raises a stall for any later Hi/Lo-touching instruction.

---
 rtl/hilo_mult_sequencer.sv | 137 +++++++++++++
 tb/tb_hilo_mult_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_sequencer.sv
// rtl/hilo_mult_sequencer.sv - iterative shift-add multiply/accumulate unit owning the Hi/Lo pair
module hilo_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [4:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_MULTU = 5'b11000;
  localparam logic [4:0] OP_MADD  = 5'b01111;
  localparam logic [4:0] OP_MSUB  = 5'b01110;
  localparam logic [4:0] OP_MTHI  = 5'b10010;
  localparam logic [4:0] OP_MTLO  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_SET = 2'd0,
    K_ADD = 2'd1,
    K_SUB = 2'd2
  } kind_t;

  state_t state, state_next;
  kind_t  kind;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p, p_next;
  logic [WIDTH-1:0]   m;
  logic               neg;

  logic               is_mul, is_hilo, is_signed, issue, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] r, hilo_cur;

  always_comb begin
    is_mul    = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) ||
                (ALUOp == OP_MADD) || (ALUOp == OP_MSUB);
    is_hilo   = is_mul || (ALUOp == OP_MTHI) || (ALUOp == OP_MTLO) ||
                (ALUOp == OP_MFHI) || (ALUOp == OP_MFLO);
    is_signed = (ALUOp != OP_MULTU);
    issue     = (state == IDLE) && Start && is_mul;
    last_iter = (cnt == CW'(WIDTH - 1));
    // Magnitude is unsigned, so the most negative value maps onto itself legally
    a_mag     = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    b_mag     = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
  end

  always_comb begin
    add_sum = {1'b0, p[2*WIDTH-1:WIDTH]};
    if (p[0]) add_sum = add_sum + {1'b0, m};
    p_next   = {add_sum, p[WIDTH-1:1]};
    r        = neg ? -p : p;
    hilo_cur = {Hi, Lo};
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = MUL;
      MUL:     if (last_iter) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state != IDLE);
    Done  = (state == ACC) && !Rst;
    Stall = Start && is_hilo && (state != IDLE) && !Rst;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Hi   <= '0;
      Lo   <= '0;
      cnt  <= '0;
      p    <= '0;
      m    <= '0;
      neg  <= 1'b0;
      kind <= K_SET;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            m    <= is_signed ? a_mag : A;
            p    <= {{WIDTH{1'b0}}, (is_signed ? b_mag : B)};
            neg  <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            cnt  <= '0;
            kind <= (ALUOp == OP_MADD) ? K_ADD :
                    (ALUOp == OP_MSUB) ? K_SUB : K_SET;
          end else if (Start && ALUOp == OP_MTHI) begin
            Hi <= A;
          end else if (Start && ALUOp == OP_MTLO) begin
            Lo <= A;
          end
        end
        MUL: begin
          p   <= p_next;
          cnt <= cnt + CW'(1);
        end
        ACC: begin
          case (kind)
            K_ADD:   {Hi, Lo} <= hilo_cur + r;
            K_SUB:   {Hi, Lo} <= hilo_cur - r;
            default: {Hi, Lo} <= r;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// tb/tb_hilo_mult_sequencer.sv - self-checking bench for hilo_mult_sequencer
module tb_hilo_mult_sequencer;

  localparam int W = 32;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_MULTU = 5'b11000;
  localparam logic [4:0] OP_MADD  = 5'b01111;
  localparam logic [4:0] OP_MSUB  = 5'b01110;
  localparam logic [4:0] OP_MTHI  = 5'b10010;
  localparam logic [4:0] OP_MTLO  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;

  logic         Clk = 1'b0;
  logic         Rst, Start;
  logic [4:0]   ALUOp;
  logic [W-1:0] A, B;
  logic         Stall, Busy, Done;
  logic [W-1:0] Hi, Lo;

  hilo_mult_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
    .Stall(Stall), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit f_is_mul(input logic [4:0] op);
    return op == OP_MULT || op == OP_MULTU || op == OP_MADD || op == OP_MSUB;
  endfunction

  function automatic bit f_is_hilo(input logic [4:0] op);
    return f_is_mul(op) || op == OP_MTHI || op == OP_MTLO || op == OP_MFHI || op == OP_MFLO;
  endfunction

  // Model: busy countdown plus a product computed with native 64-bit arithmetic
  int          m_cnt = 0;
  logic [4:0]  m_op;
  logic [63:0] m_prod;
  logic [63:0] m_hl = '0;
  bit          armed = 1'b0;

  always @(posedge Clk) begin
    longint sa, sb;
    logic [63:0] ua, ub;
    if (Rst) begin
      m_cnt = 0;
      m_hl  = '0;
      armed = 1'b1;
    end else if (m_cnt == 0) begin
      if (Start && f_is_mul(ALUOp)) begin
        m_cnt = W + 1;
        m_op  = ALUOp;
        if (ALUOp == OP_MULTU) begin
          ua = {32'b0, A};
          ub = {32'b0, B};
          m_prod = ua * ub;
        end else begin
          sa = $signed(A);
          sb = $signed(B);
          m_prod = sa * sb;
        end
      end else if (Start && ALUOp == OP_MTHI) begin
        m_hl[63:32] = A;
      end else if (Start && ALUOp == OP_MTLO) begin
        m_hl[31:0] = A;
      end
    end else begin
      if (m_cnt == 1) begin
        if (m_op == OP_MADD)      m_hl = m_hl + m_prod;
        else if (m_op == OP_MSUB) m_hl = m_hl - m_prod;
        else                      m_hl = m_prod;
      end
      m_cnt = m_cnt - 1;
    end
  end

  always @(negedge Clk) begin
    if (armed) begin
      chk("busy", Busy, 64'(m_cnt != 0));
      chk("done", Done, 64'(m_cnt == 1 && !Rst));
      chk("stall", Stall, 64'(Start && f_is_hilo(ALUOp) && m_cnt != 0 && !Rst));
      chk("hi", Hi, m_hl[63:32]);
      chk("lo", Lo, m_hl[31:0]);
    end
  end

  task automatic present(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int stalls);
    stalls = 0;
    Start = 1'b1; ALUOp = op; A = a; B = b;
    @(negedge Clk);
    while (Stall && stalls < 100) begin
      stalls++;
      @(negedge Clk);
    end
    if (stalls >= 100) chk("stall_timeout", 64'(stalls), 64'd0);
    @(posedge Clk); #1;
    Start = 1'b0; ALUOp = OP_ADD; A = '0; B = '0;
  endtask

  task automatic wait_idle(output int bc, output int dc);
    bit idle;
    bc = 0; dc = 0; idle = 1'b0;
    while (!idle && bc < 100) begin
      @(negedge Clk);
      if (!Busy) idle = 1'b1;
      else begin
        bc++;
        if (Done) dc++;
      end
    end
    if (!idle) chk("busy_timeout", 64'(bc), 64'd0);
    @(posedge Clk); #1;
  endtask

  task automatic run(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     output int st, output int bc, output int dc);
    present(op, a, b, st);
    wait_idle(bc, dc);
  endtask

  initial begin
    int st, bc, dc, dn;
    Rst = 1'b1; Start = 1'b0; ALUOp = OP_ADD; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    chk("reset_hi", Hi, 64'd0);
    chk("reset_lo", Lo, 64'd0);
    chk("reset_busy", Busy, 64'd0);

    run(OP_MULT, 32'hFFFFFFFD, 32'd7, st, bc, dc);
    chk("mult_issue_stall", 64'(st), 64'd0);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    chk("mult_done_pulses", 64'(dc), 64'd1);
    chk("mult_hi", Hi, 64'hFFFFFFFF);
    chk("mult_lo", Lo, 64'hFFFFFFEB);

    run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, st, bc, dc);
    chk("multu_hi", Hi, 64'hFFFFFFFE);
    chk("multu_lo", Lo, 64'h00000001);

    run(OP_MULT, 32'h80000000, 32'h80000000, st, bc, dc);
    chk("corner_hi", Hi, 64'h40000000);
    chk("corner_lo", Lo, 64'h00000000);

    present(OP_MTHI, 32'd0, 32'd0, st);
    present(OP_MTLO, 32'd10, 32'd0, st);
    chk("mtlo_busy", Busy, 64'd0);
    chk("mtlo_lo", Lo, 64'd10);
    run(OP_MADD, 32'd4, 32'd5, st, bc, dc);
    chk("madd_hi", Hi, 64'd0);
    chk("madd_lo", Lo, 64'd30);
    run(OP_MSUB, 32'd2, 32'd20, st, bc, dc);
    chk("msub_hi", Hi, 64'hFFFFFFFF);
    chk("msub_lo", Lo, 64'hFFFFFFF6);

    // Issue, three add cycles mid-MUL, one quiet cycle, then mflo
    present(OP_MULT, 32'h1234, 32'h10, st);
    Start = 1'b1; ALUOp = OP_ADD; A = 32'd1; B = 32'd2;
    repeat (3) @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk); #1;
    present(OP_MFLO, 32'd0, 32'd0, st);
    chk("mflo_stall_cycles", 64'(st), 64'd29);
    chk("mflo_busy", Busy, 64'd0);
    chk("mflo_lo", Lo, 64'h12340);

    present(OP_MULT, 32'd5, 32'd9, st);
    repeat (10) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    chk("rst_busy", Busy, 64'd0);
    chk("rst_hi", Hi, 64'd0);
    chk("rst_lo", Lo, 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    chk("rst_no_done", 64'(dn), 64'd0);
    @(posedge Clk); #1;

    run(OP_MULTU, 32'd6, 32'd7, st, bc, dc);
    chk("post_rst_busy_cycles", 64'(bc), 64'd33);
    chk("post_rst_hi", Hi, 64'd0);
    chk("post_rst_lo", Lo, 64'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
